dual_port_ram_pipe: RTL and testbench

Single-clock, parametrised simple dual-port RAM: one write port and one read port, both on Clk.
- Write side: per-byte write mask.
- Read side: configurable read latency (1 or 2), RValid qualifier, and a selectable read/write collision mode.
- After every reset, a built-in clear sequencer zeroes the whole array before Ready asserts.
- Used as the storage cell for the next-generation FIFOs, register files and cache tag/data arrays.

---
 rtl/dual_port_ram_pipe_pkg.sv | 31 +++
 rtl/dual_port_ram_pipe_if.sv | 37 +++
 rtl/dual_port_ram_pipe_rdstage.sv | 37 +++
 rtl/dual_port_ram_pipe.sv | 181 ++++++++++++++++++
 tb/tb_dual_port_ram_pipe.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dual_port_ram_pipe_pkg.sv
// dual_port_ram_pipe_pkg: shared types and helpers for the pipelined dual-port RAM.
// Optional feature macro: DUAL_PORT_RAM_PIPE_PARITY_EN (per-byte even parity).
package dual_port_ram_pipe_pkg;

  // CLEAR zeroes the array after reset; RUN serves the ports until the next reset.
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  // Widest word byte_merge handles; words are zero-extended into this container.
  localparam int MAX_BYTES = 64;
  localparam int MAX_W     = MAX_BYTES * 8;

  // Address width that stays legal for a single-word array.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Take new bytes where mask is set, keep old bytes elsewhere.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]     old_w,
                                                  input logic [MAX_W-1:0]     new_w,
                                                  input logic [MAX_BYTES-1:0] mask);
    logic [MAX_W-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_BYTES; i++)
      if (mask[i]) m[i*8 +: 8] = new_w[i*8 +: 8];
    return m;
  endfunction

endpackage

// File: rtl/dual_port_ram_pipe_if.sv
// dual_port_ram_pipe_if: write/read port bundle for dual_port_ram_pipe.
// Optional feature macro: DUAL_PORT_RAM_PIPE_PARITY_EN adds ParityErr.
interface dual_port_ram_pipe_if #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 5
);
  logic                   WEnc;
  logic [AddrWidth-1:0]   WAddr;
  logic [DataWidth-1:0]   WData;
  logic [DataWidth/8-1:0] WMask;
  logic                   REnc;
  logic [AddrWidth-1:0]   RAddr;
  logic [DataWidth-1:0]   RData;
  logic                   RValid;
  logic                   Ready;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
  logic                   ParityErr;
`endif

  // Requester side.
  modport master (
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
    input  ParityErr,
`endif
    output WEnc, WAddr, WData, WMask, REnc, RAddr,
    input  RData, RValid, Ready
  );

  // RAM side.
  modport slave (
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
    output ParityErr,
`endif
    input  WEnc, WAddr, WData, WMask, REnc, RAddr,
    output RData, RValid, Ready
  );
endinterface

// File: rtl/dual_port_ram_pipe_rdstage.sv
// dual_port_ram_pipe_rdstage: one read-pipeline register for {valid, data[, parity_err]}.
// Optional feature macro: DUAL_PORT_RAM_PIPE_PARITY_EN adds the parity_err slot.
module dual_port_ram_pipe_rdstage #(
  parameter int DataWidth = 64
)(
  input  logic                 Clk,
  input  logic                 Rst,
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
  input  logic                 in_perr,
  output logic                 out_perr,
`endif
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  output logic [DataWidth-1:0] out_data
);

  // Valid advances every cycle; payload only moves with a valid so data holds between reads.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
      out_perr  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
        out_perr <= in_perr;
`endif
      end
    end
  end

endmodule

// File: rtl/dual_port_ram_pipe.sv
// dual_port_ram_pipe: single-clock simple dual-port RAM with byte mask, 1/2-cycle read
// latency, read-first/write-first collision mode and a post-reset clear sequencer.
// Optional feature macro: DUAL_PORT_RAM_PIPE_PARITY_EN (per-byte even parity, ParityErr).
module dual_port_ram_pipe
  import dual_port_ram_pipe_pkg::*;
#(
  parameter int DataWidth   = 64,
  parameter int Depth       = 32,
  parameter int ReadLatency = 1,
  parameter int WriteFirst  = READ_FIRST
)(
  input  logic                 Clk,
  input  logic                 Rst,
  dual_port_ram_pipe_if.slave  bus
);

  localparam int AddrWidth = clog2_min1(Depth);
  localparam int NB        = DataWidth / 8;

  logic [DataWidth-1:0] ram_mem [Depth];

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] clr_ptr_q, clr_ptr_d;
  logic                 ready;

  logic [AddrWidth-1:0] waddr, raddr;
  logic                 w_inr, r_inr, coll;
  logic [MAX_W-1:0]     w_merge_full;
  logic [DataWidth-1:0] w_merged;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_wa;
  logic [DataWidth-1:0] mem_wd;
  logic [DataWidth-1:0] rd0;

  logic [ReadLatency:0]                vld_pipe;
  logic [ReadLatency:0][DataWidth-1:0] dat_pipe;

`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
  logic [NB-1:0]        par_mem [Depth];
  logic [NB-1:0]        w_par, mem_wp, r_par;
  logic                 perr0;
  logic [ReadLatency:0] perr_pipe;
`endif

  assign waddr = bus.WAddr;
  assign raddr = bus.RAddr;
  assign ready = (state_q == RUN);

  // Only non-power-of-two depths can see addresses past the end.
  assign w_inr = 32'(waddr) < 32'(Depth);
  assign r_inr = 32'(raddr) < 32'(Depth);
  assign coll  = bus.WEnc && ready && w_inr && (waddr == raddr);

  // FSM state and clear pointer.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Walk the clear pointer across the array once, then stay in RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + AddrWidth'(1);
      if (32'(clr_ptr_q) == 32'(Depth - 1)) begin
        state_d   = RUN;
        clr_ptr_d = '0;
      end
    end
  end

  // The merged word serves both the array write and write-first forwarding
  // (a collision is by definition the same word).
  assign w_merge_full = byte_merge(MAX_W'(ram_mem[waddr]), MAX_W'(bus.WData),
                                   MAX_BYTES'(bus.WMask));
  assign w_merged     = w_merge_full[DataWidth-1:0];

  if (DataWidth < MAX_W) begin : g_merge_hi
    logic unused_merge_hi;
    assign unused_merge_hi = ^w_merge_full[MAX_W-1:DataWidth];
  end

`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
  // Per-byte parity follows the same mask as the data bytes.
  always_comb begin
    w_par = par_mem[waddr];
    for (int i = 0; i < NB; i++)
      if (bus.WMask[i]) w_par[i] = ^bus.WData[i*8 +: 8];
  end
`endif

  // Array write mux: clear sequencer owns the port until RUN.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = w_merged;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
    mem_wp = w_par;
`endif
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = clr_ptr_q;
      mem_wd = '0;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
      mem_wp = '0;
`endif
    end else if (bus.WEnc && w_inr) begin
      mem_we = 1'b1;
    end
  end

  // Storage; contents are deliberately not reset, the sequencer clears them.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      ram_mem[mem_wa] <= mem_wd;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
      par_mem[mem_wa] <= mem_wp;
`endif
    end
  end

  // Read word selection: zero past the end, forwarded merge on write-first collision.
  always_comb begin
    rd0 = '0;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
    r_par = '0;
    perr0 = 1'b0;
`endif
    if (r_inr) begin
      rd0 = ram_mem[raddr];
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
      r_par = par_mem[raddr];
`endif
      if (WriteFirst == WRITE_FIRST && coll) begin
        rd0 = w_merged;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
        r_par = w_par;
`endif
      end
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
      for (int i = 0; i < NB; i++)
        if ((^rd0[i*8 +: 8]) != r_par[i]) perr0 = 1'b1;
`endif
    end
  end

  assign vld_pipe[0] = bus.REnc && ready;
  assign dat_pipe[0] = rd0;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
  assign perr_pipe[0] = perr0;
`endif

  for (genvar s = 0; s < ReadLatency; s++) begin : g_stage
    dual_port_ram_pipe_rdstage #(.DataWidth(DataWidth)) u_stage (
      .Clk       (Clk),
      .Rst       (Rst),
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
      .in_perr   (perr_pipe[s]),
      .out_perr  (perr_pipe[s+1]),
`endif
      .in_valid  (vld_pipe[s]),
      .in_data   (dat_pipe[s]),
      .out_valid (vld_pipe[s+1]),
      .out_data  (dat_pipe[s+1])
    );
  end

  assign bus.RValid = vld_pipe[ReadLatency];
  assign bus.RData  = dat_pipe[ReadLatency];
  assign bus.Ready  = ready;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
  assign bus.ParityErr = vld_pipe[ReadLatency] & perr_pipe[ReadLatency];
`endif

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// tb_dual_port_ram_pipe: three DUTs share one stimulus stream:
//   0: Depth 16, latency 1, read-first   1: Depth 16, latency 2, write-first
//   2: Depth 12, latency 1, read-first (out-of-range addresses; parity flip when
//      DUAL_PORT_RAM_PIPE_PARITY_EN is defined).
module tb_dual_port_ram_pipe;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        wenc, renc;
  logic [3:0]  waddr, raddr, wmask;
  logic [31:0] wdata;

  logic [2:0]  rv, rdy;
  logic [31:0] rd [3];
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
  logic [2:0]  pe;
`endif

  int          nvec = 0;
  int          nerr = 0;
  int          lat [3] = '{1, 2, 1};
  logic [3:0]  ra  [16];
  logic [31:0] ex  [3][16];
  logic        pex [3][16];

  always #5 Clk = ~Clk;

  dual_port_ram_pipe_if #(.DataWidth(32), .AddrWidth(4)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].WEnc  = wenc;
    assign bus[g].WAddr = waddr;
    assign bus[g].WData = wdata;
    assign bus[g].WMask = wmask;
    assign bus[g].REnc  = renc;
    assign bus[g].RAddr = raddr;
    assign rv[g]  = bus[g].RValid;
    assign rdy[g] = bus[g].Ready;
    assign rd[g]  = bus[g].RData;
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
    assign pe[g]  = bus[g].ParityErr;
`endif
    dual_port_ram_pipe #(
      .DataWidth   (32),
      .Depth       ((g == 2) ? 12 : 16),
      .ReadLatency ((g == 1) ? 2 : 1),
      .WriteFirst  ((g == 1) ? 1 : 0)
    ) u_dut (
      .Clk (Clk),
      .Rst (rst_n),
      .bus (bus[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    wenc = 1'b1; waddr = a; wdata = d; wmask = m;
    tick();
    wenc = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [3:0] a, input logic [31:0] d);
    ra[k] = a;
    for (int i = 0; i < 3; i++) begin
      ex[i][k]  = d;
      pex[i][k] = 1'b0;
    end
  endtask

  // Back-to-back reads of ra[0..n-1]; any write set up beforehand lands on the first edge.
  task automatic rd_burst(input int n);
    for (int k = 0; k < n + 2; k++) begin
      renc = (k < n);
      if (k < n) raddr = ra[k];
      tick();
      if (k == 0) wenc = 1'b0;
      for (int d = 0; d < 3; d++) begin
        int j = k - (lat[d] - 1);
        logic v = (j >= 0 && j < n);
        chk($sformatf("rvalid d%0d k%0d", d, k), 32'(rv[d]), 32'(v));
        if (v)
          chk($sformatf("rdata d%0d k%0d", d, k), rd[d], ex[d][j]);
        else if (j == n)
          chk($sformatf("rhold d%0d", d), rd[d], ex[d][n-1]);
`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
        chk($sformatf("perr d%0d k%0d", d, k), 32'(pe[d]), v ? 32'(pex[d][j]) : 32'd0);
`endif
      end
    end
    renc = 1'b0;
  endtask

  // Release-to-Ready count, with ignored requests poked during the clear.
  task automatic clear_seq();
    int   r0 = 0, r1 = 0, r2 = 0;
    logic anyv = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      wenc  = (i >= 6 && i <= 10);
      renc  = wenc;
      waddr = 4'd2; wdata = 32'hDEADBEEF; wmask = 4'hF; raddr = 4'd0;
      tick();
      if (rv != 3'b000) anyv = 1'b1;
      if (rdy[0] && r0 == 0) r0 = i;
      if (rdy[1] && r1 == 0) r1 = i;
      if (rdy[2] && r2 == 0) r2 = i;
    end
    wenc = 1'b0; renc = 1'b0;
    chk("ready cycle d0", 32'(r0), 32'd16);
    chk("ready cycle d1", 32'(r1), 32'd16);
    chk("ready cycle d2", 32'(r2), 32'd12);
    chk("no rvalid in clear", 32'(anyv), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; wenc = 1'b0; renc = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wmask = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst ready d%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("rst rvalid d%0d", d), 32'(rv[d]), 32'd0);
      chk($sformatf("rst rdata d%0d", d), rd[d], 32'd0);
    end
    rst_n = 1'b1;
    clear_seq();

    // Whole array reads zero; addresses 12..15 are past the end of DUT 2.
    for (int k = 0; k < 16; k++) set_rd(k, 4'(k), 32'd0);
    rd_burst(16);

    // Latency/throughput with distinct words at 0..3.
    wr(4'd0, 32'h10000001, 4'hF);
    wr(4'd1, 32'h20000002, 4'hF);
    wr(4'd2, 32'h30000003, 4'hF);
    wr(4'd3, 32'h40000004, 4'hF);
    set_rd(0, 4'd0, 32'h10000001); set_rd(1, 4'd1, 32'h20000002);
    set_rd(2, 4'd2, 32'h30000003); set_rd(3, 4'd3, 32'h40000004);
    rd_burst(4);

    // Byte mask, then a mask-0 write alongside the read that must change nothing.
    wr(4'd5, 32'hAABBCCDD, 4'hF);
    wr(4'd5, 32'h11223344, 4'b0101);
    wenc = 1'b1; waddr = 4'd5; wdata = 32'h0; wmask = 4'h0;
    set_rd(0, 4'd5, 32'hAA22CC44); set_rd(1, 4'd5, 32'hAA22CC44);
    rd_burst(2);

    // Same-cycle collision on addr 7.
    wr(4'd7, 32'h12345678, 4'hF);
    wenc = 1'b1; waddr = 4'd7; wdata = 32'hFFFFFFFF; wmask = 4'b0011;
    set_rd(0, 4'd7, 32'h12345678);
    ex[1][0] = 32'h1234FFFF;
    rd_burst(1);

    // Merged word landed in all; a read right after a write sees it.
    wenc = 1'b1; waddr = 4'd8; wdata = 32'h0BADF00D; wmask = 4'hF;
    set_rd(0, 4'd7, 32'h1234FFFF); set_rd(1, 4'd8, 32'h0BADF00D);
    rd_burst(2);

    // Addr 13 is out of range only for DUT 2; neighbours it could alias must stay intact.
    wr(4'd13, 32'h55555555, 4'hF);
    set_rd(0, 4'd13, 32'h55555555);
    ex[2][0] = 32'h0;
    set_rd(1, 4'd1, 32'h20000002); set_rd(2, 4'd5, 32'hAA22CC44);
    rd_burst(3);

`ifdef DUAL_PORT_RAM_PIPE_PARITY_EN
    // Flip bit 0 of the stored word at addr 2 in DUT 2 behind the parity bits.
    g_dut[2].u_dut.ram_mem[2] = 32'h30000002;
    set_rd(0, 4'd2, 32'h30000003); set_rd(1, 4'd3, 32'h40000004);
    ex[2][0]  = 32'h30000002;
    pex[2][0] = 1'b1;
    rd_burst(2);
`endif

    // Reset with a read in flight: nothing comes out, Ready drops at once.
    renc = 1'b1; raddr = 4'd5;
    tick();
    renc = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid rst ready d%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("mid rst rvalid d%0d", d), 32'(rv[d]), 32'd0);
      chk($sformatf("mid rst rdata d%0d", d), rd[d], 32'd0);
    end
    renc = 1'b1; wenc = 1'b1; waddr = 4'd4; wdata = 32'hCAFEF00D; wmask = 4'hF;
    tick();
    chk("mid rst dropped reads", 32'(rv), 32'd0);
    tick();
    renc = 1'b0; wenc = 1'b0;
    rst_n = 1'b1;
    clear_seq();
    set_rd(0, 4'd5, 32'h0); set_rd(1, 4'd7, 32'h0); set_rd(2, 4'd4, 32'h0);
    rd_burst(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
